// File: rtl/c5efa7_fpga_bup_qsys_sysid_checker.sv
`default_nettype none
// ============================================================================
// Module   : c5efa7_fpga_bup_qsys_sysid_checker
// Brief    : Avalon-MM read master that reads the sysid ID and timestamp words
//            and reports pass/mismatch/timeout status to the portal control.
// Revision : 1.0 - initial release
// ============================================================================
module c5efa7_fpga_bup_qsys_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID       = 32'hFACECAFE,
    parameter logic [31:0] EXPECTED_TS       = 32'h511B3C8E,
    parameter int unsigned CHECK_TS          = 1,
    parameter int unsigned USE_READDATAVALID = 0,
    parameter int unsigned READ_LATENCY      = 0,
    parameter int unsigned TIMEOUT_CYCLES    = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        m_address,
    output logic        m_read,
    input  logic        m_waitrequest,
    input  logic [31:0] m_readdata,
    input  logic        m_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_mismatch,
    output logic        ts_mismatch,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam logic [15:0] c_to_last = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] c_rd_lat  = 16'(READ_LATENCY);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ID_CMD  = 3'd1,
        ST_ID_DATA = 3'd2,
        ST_TS_CMD  = 3'd3,
        ST_TS_DATA = 3'd4,
        ST_FIN     = 3'd5
    } state_t;

    state_t      r_state;
    logic [15:0] r_to_cnt;
    logic [15:0] r_lat_cnt;

    logic w_in_cmd;
    logic w_in_data;
    logic w_is_ts;
    logic w_accept;
    logic w_capture;
    logic w_to_expire;
    logic w_id_miss;
    logic w_ts_miss;

    assign w_in_cmd    = (r_state == ST_ID_CMD)  || (r_state == ST_TS_CMD);
    assign w_in_data   = (r_state == ST_ID_DATA) || (r_state == ST_TS_DATA);
    assign w_is_ts     = (r_state == ST_TS_CMD)  || (r_state == ST_TS_DATA);
    assign w_accept    = w_in_cmd && m_read && !m_waitrequest;
    assign w_id_miss   = (m_readdata != EXPECTED_ID);
    assign w_ts_miss   = (CHECK_TS != 0) && (m_readdata != EXPECTED_TS);

    // Capture point depends on the slave timing mode chosen at build time.
    always_comb begin
        w_capture = 1'b0;
        if (USE_READDATAVALID != 0) begin
            w_capture = w_in_data && m_readdatavalid;
        end else if (READ_LATENCY == 0) begin
            w_capture = w_accept;
        end else begin
            w_capture = w_in_data && (r_lat_cnt == c_rd_lat);
        end
    end

    // A capture landing on the last allowed cycle takes priority over timeout.
    assign w_to_expire = (w_in_cmd || w_in_data) && (r_to_cnt == c_to_last) && !w_capture;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_to_cnt    <= 16'd0;
            r_lat_cnt   <= 16'd0;
            m_address   <= 1'b0;
            m_read      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            id_mismatch <= 1'b0;
            ts_mismatch <= 1'b0;
            timeout     <= 1'b0;
            id_value    <= 32'd0;
            ts_value    <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE, ST_FIN: begin
                    if (start) begin
                        r_state     <= ST_ID_CMD;
                        r_to_cnt    <= 16'd0;
                        r_lat_cnt   <= 16'd0;
                        m_address   <= 1'b0;
                        m_read      <= 1'b1;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        id_mismatch <= 1'b0;
                        ts_mismatch <= 1'b0;
                        timeout     <= 1'b0;
                        id_value    <= 32'd0;
                        ts_value    <= 32'd0;
                    end
                end
                ST_ID_CMD, ST_ID_DATA, ST_TS_CMD, ST_TS_DATA: begin
                    if (w_capture) begin
                        if (w_is_ts) begin
                            ts_value    <= m_readdata;
                            ts_mismatch <= w_ts_miss;
                            pass        <= !id_mismatch && !w_ts_miss;
                            r_state     <= ST_FIN;
                            m_read      <= 1'b0;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                        end else begin
                            id_value    <= m_readdata;
                            id_mismatch <= w_id_miss;
                            r_state     <= ST_TS_CMD;
                            r_to_cnt    <= 16'd0;
                            m_address   <= 1'b1;
                            m_read      <= 1'b1;
                        end
                    end else if (w_to_expire) begin
                        timeout <= 1'b1;
                        pass    <= 1'b0;
                        r_state <= ST_FIN;
                        m_read  <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + 16'd1;
                        if (w_accept) begin
                            r_state   <= w_is_ts ? ST_TS_DATA : ST_ID_DATA;
                            m_read    <= 1'b0;
                            r_lat_cnt <= 16'd1;
                        end else if (w_in_data) begin
                            r_lat_cnt <= r_lat_cnt + 16'd1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    m_read  <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_c5efa7_fpga_bup_qsys_sysid_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_c5efa7_fpga_bup_qsys_sysid_checker
// Brief    : Directed bench for the sysid checker in three timing configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_c5efa7_fpga_bup_qsys_sysid_checker;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // ---------------- DUT a: fixed latency 0, TIMEOUT 8 ----------------
    logic        start_a = 1'b0;
    logic [31:0] a_id = 32'd0, a_ts = 32'd0;
    logic [15:0] id_stall = 16'd0, ts_stall = 16'd0, a_cyc;
    logic        a_addr, a_read, a_wait, a_busy, a_done, a_pass, a_idm, a_tsm, a_to;
    logic [31:0] a_rdata, a_idv, a_tsv;

    assign a_wait  = a_read && (a_cyc < (a_addr ? ts_stall : id_stall));
    assign a_rdata = a_addr ? a_ts : a_id;
    always @(posedge clk) begin
        if (reset || !(a_read && a_wait)) a_cyc <= 16'd0;
        else                              a_cyc <= a_cyc + 16'd1;
    end

    c5efa7_fpga_bup_qsys_sysid_checker #(.TIMEOUT_CYCLES(8)) dut_a (
        .clock(clk), .reset(reset), .start(start_a),
        .m_address(a_addr), .m_read(a_read), .m_waitrequest(a_wait),
        .m_readdata(a_rdata), .m_readdatavalid(1'b0),
        .busy(a_busy), .done(a_done), .pass(a_pass),
        .id_mismatch(a_idm), .ts_mismatch(a_tsm), .timeout(a_to),
        .id_value(a_idv), .ts_value(a_tsv)
    );

    // ---------------- DUT b: CHECK_TS=0, fixed latency 2 ----------------
    logic        start_b = 1'b0;
    logic [31:0] b_id = 32'd0, b_ts = 32'd0;
    logic [7:0]  b_lat;
    logic        b_addr, b_read, b_busy, b_done, b_pass, b_idm, b_tsm, b_to;
    logic [31:0] b_rdata, b_idv, b_tsv;

    // Data is only valid exactly two cycles after the accept.
    assign b_rdata = (b_lat == 8'd2) ? (b_addr ? b_ts : b_id) : 32'hDEADBEEF;
    always @(posedge clk) begin
        if (reset)                           b_lat <= 8'd0;
        else if (b_read)                     b_lat <= 8'd1;
        else if (b_lat != 0 && b_lat < 8'd8) b_lat <= b_lat + 8'd1;
    end

    c5efa7_fpga_bup_qsys_sysid_checker #(.CHECK_TS(0), .READ_LATENCY(2)) dut_b (
        .clock(clk), .reset(reset), .start(start_b),
        .m_address(b_addr), .m_read(b_read), .m_waitrequest(1'b0),
        .m_readdata(b_rdata), .m_readdatavalid(1'b0),
        .busy(b_busy), .done(b_done), .pass(b_pass),
        .id_mismatch(b_idm), .ts_mismatch(b_tsm), .timeout(b_to),
        .id_value(b_idv), .ts_value(b_tsv)
    );

    // ---------------- DUT c: readdatavalid mode ----------------
    logic        start_c = 1'b0;
    logic        c_addr, c_read, c_busy, c_done, c_pass, c_idm, c_tsm, c_to;
    logic        c_valid = 1'b0;
    int          c_pend = 0;
    logic [31:0] c_rdata, c_idv, c_tsv;

    // Slave model keeps running through DUT reset so a stray valid reaches an idle DUT.
    assign c_rdata = c_valid ? (c_addr ? 32'h511B3C8E : 32'hFACECAFE) : 32'hBAD0BAD0;
    always @(posedge clk) begin
        c_valid <= (c_pend == 1);
        if (c_read)          c_pend <= 2;
        else if (c_pend != 0) c_pend <= c_pend - 1;
    end

    c5efa7_fpga_bup_qsys_sysid_checker #(.USE_READDATAVALID(1)) dut_c (
        .clock(clk), .reset(reset), .start(start_c),
        .m_address(c_addr), .m_read(c_read), .m_waitrequest(1'b0),
        .m_readdata(c_rdata), .m_readdatavalid(c_valid),
        .busy(c_busy), .done(c_done), .pass(c_pass),
        .id_mismatch(c_idm), .ts_mismatch(c_tsm), .timeout(c_to),
        .id_value(c_idv), .ts_value(c_tsv)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] id_word;
        logic [31:0] ts_word;
        logic [15:0] id_st;
        logic [15:0] ts_st;
        int          restart_at;
        int          exp_n;
        logic        exp_pass;
        logic        exp_idm;
        logic        exp_tsm;
        logic        exp_to;
        logic [31:0] exp_idv;
        logic [31:0] exp_tsv;
    } vec_t;

    vec_t vecs[9];

    task automatic run_a(input int idx, input vec_t v);
        int   n;
        logic hold_ok, pw, pr, pa;
        a_id = v.id_word; a_ts = v.ts_word; id_stall = v.id_st; ts_stall = v.ts_st;
        @(negedge clk);
        start_a = 1'b1;
        n = 0; hold_ok = 1'b1; pw = 1'b0; pr = 1'b0; pa = 1'b0;
        while (n < 40) begin
            @(posedge clk); #1;
            n++;
            start_a = (n == v.restart_at);
            if (n == 1) chk($sformatf("v%0d_busy_on", idx), {31'd0, a_busy, a_done}, 32'd2);
            if (a_done) break;
            if (pw && (a_read !== pr || a_addr !== pa)) hold_ok = 1'b0;
            pw = a_wait; pr = a_read; pa = a_addr;
        end
        start_a = 1'b0;
        chk($sformatf("v%0d_cycles", idx), n, v.exp_n);
        chk($sformatf("v%0d_pass", idx), a_pass, v.exp_pass);
        chk($sformatf("v%0d_flags", idx), {a_idm, a_tsm, a_to}, {v.exp_idm, v.exp_tsm, v.exp_to});
        chk($sformatf("v%0d_id_value", idx), a_idv, v.exp_idv);
        chk($sformatf("v%0d_ts_value", idx), a_tsv, v.exp_tsv);
        chk($sformatf("v%0d_idle_bus", idx), {a_busy, a_read}, 2'b00);
        chk($sformatf("v%0d_hold", idx), hold_ok, 1'b1);
    endtask

    int n;

    initial begin
        vecs[0] = '{32'hFACECAFE, 32'h511B3C8E, 16'd0, 16'd0, 0, 3, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFACECAFE, 32'h511B3C8E};
        vecs[1] = '{32'h12345678, 32'h511B3C8E, 16'd0, 16'd0, 0, 3, 1'b0, 1'b1, 1'b0, 1'b0, 32'h12345678, 32'h511B3C8E};
        vecs[2] = '{32'hFACECAFE, 32'h00000000, 16'd0, 16'd0, 0, 3, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFACECAFE, 32'h00000000};
        vecs[3] = '{32'hFACECAFE, 32'h511B3C8E, 16'd5, 16'd5, 3, 13, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFACECAFE, 32'h511B3C8E};
        vecs[4] = '{32'hFACECAFE, 32'h511B3C8E, 16'd0, 16'hFFFF, 0, 10, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFACECAFE, 32'h00000000};
        vecs[5] = '{32'hFACECAFE, 32'h511B3C8E, 16'hFFFF, 16'd0, 0, 9, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00000000, 32'h00000000};
        vecs[6] = '{32'hFACECAFE, 32'h511B3C8E, 16'd7, 16'd0, 0, 10, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFACECAFE, 32'h511B3C8E};
        vecs[7] = '{32'hFACECAFE, 32'h511B3C8E, 16'd0, 16'd7, 0, 10, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFACECAFE, 32'h511B3C8E};
        vecs[8] = '{32'h00000000, 32'h00000000, 16'd0, 16'd8, 0, 10, 1'b0, 1'b1, 1'b0, 1'b1, 32'h00000000, 32'h00000000};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_ctrl", {a_busy, a_done, a_pass, a_idm, a_tsm, a_to, a_read, a_addr}, 8'd0);
        chk("rst_a_values", a_idv | a_tsv, 32'd0);
        chk("rst_b_ctrl", {b_busy, b_done, b_pass, b_idm, b_tsm, b_to, b_read, b_addr}, 8'd0);
        chk("rst_c_ctrl", {c_busy, c_done, c_pass, c_idm, c_tsm, c_to, c_read, c_addr}, 8'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) run_a(i, vecs[i]);

        // Fixed latency 2, timestamp not compared.
        for (int r = 0; r < 2; r++) begin
            b_id = (r == 0) ? 32'hFACECAFE : 32'h12345678;
            b_ts = (r == 0) ? 32'h00000000 : 32'h511B3C8E;
            @(negedge clk);
            start_b = 1'b1;
            n = 0;
            while (n < 40) begin
                @(posedge clk); #1;
                n++;
                start_b = 1'b0;
                if (n == 1) chk("b_id_cmd", {b_read, b_addr}, 2'b10);
                if (n == 2) chk("b_id_data", {b_read, b_busy}, 2'b01);
                if (n == 4) chk("b_ts_cmd", {b_read, b_addr}, 2'b11);
                if (b_done) break;
            end
            chk($sformatf("b%0d_cycles", r), n, 7);
            chk($sformatf("b%0d_flags", r), {b_pass, b_idm, b_tsm, b_to}, (r == 0) ? 4'b1000 : 4'b0100);
            chk($sformatf("b%0d_id_value", r), b_idv, b_id);
            chk($sformatf("b%0d_ts_value", r), b_tsv, b_ts);
        end

        // readdatavalid mode: reset in TS_DATA, then a clean run.
        @(negedge clk);
        start_c = 1'b1;
        n = 0;
        while (n < 6) begin
            @(posedge clk); #1;
            n++;
            start_c = 1'b0;
        end
        chk("c_in_ts_data", {c_busy, c_read, c_addr, c_done}, 4'b1010);
        chk("c_id_captured", c_idv, 32'hFACECAFE);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("c_rst_ctrl", {c_busy, c_done, c_pass, c_idm, c_tsm, c_to, c_read, c_addr}, 8'd0);
        chk("c_rst_values", c_idv | c_tsv, 32'd0);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("c_stray_valid", {c_busy, c_done}, 2'b00);
        chk("c_stray_ts", c_tsv, 32'd0);
        @(negedge clk);
        start_c = 1'b1;
        n = 0;
        while (n < 40) begin
            @(posedge clk); #1;
            n++;
            start_c = 1'b0;
            if (c_done) break;
        end
        chk("c_cycles", n, 9);
        chk("c_flags", {c_pass, c_idm, c_tsm, c_to}, 4'b1000);
        chk("c_id_value", c_idv, 32'hFACECAFE);
        chk("c_ts_value", c_tsv, 32'h511B3C8E);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
